// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter between NUM_REQ packet
// sources and serialises each granted request as SYNC, CMD, LEN, payload[0..LEN-1].
module uart_tx_frame_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_LEN   = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hFF
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic [NUM_REQ-1:0]      REQ,
  input  logic [8*NUM_REQ-1:0]    REQ_CMD,
  input  logic [3*NUM_REQ-1:0]    REQ_LEN,
  input  logic [32*NUM_REQ-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]      ACK,
  output logic [2:0]              GRANT_ID,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [7:0]              TX_DATA,
  output logic                    TX_START,
  input  logic                    TX_BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAITTX
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  cmd;
  logic [2:0]  len;
  logic [31:0] data;

  logic               found;
  logic [2:0]         win;
  logic [NUM_REQ-1:0] req_sh;
  int unsigned        cand;
  logic [7:0]         sel_cmd;
  logic [2:0]         sel_len_raw;
  logic [2:0]         sel_len;
  logic [31:0]        sel_data;
  logic [NUM_REQ-1:0] ack_sel;
  logic [7:0]         byte_sel;
  logic               last_byte;

  // Search starts one past the last grant and wraps, so the previous winner is tried last.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    req_sh = '0;
    cand   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand   = (32'(GRANT_ID) + k) % NUM_REQ;
      req_sh = REQ >> cand;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        win   = 3'(cand);
      end
    end
  end

  always_comb begin
    sel_cmd     = 8'(REQ_CMD >> (8 * 32'(win)));
    sel_len_raw = 3'(REQ_LEN >> (3 * 32'(win)));
    sel_len     = (32'(sel_len_raw) > MAX_LEN) ? 3'(MAX_LEN) : sel_len_raw;
    sel_data    = 32'(REQ_DATA >> (32 * 32'(win)));
    ack_sel     = NUM_REQ'(1) << win;
  end

  always_comb begin
    byte_sel = '0;
    case (idx)
      3'd0:    byte_sel = SYNC_BYTE;
      3'd1:    byte_sel = cmd;
      3'd2:    byte_sel = {5'b0, len};
      default: byte_sel = 8'(data >> (32'(idx - 3'd3) * 8));
    endcase
    last_byte = (idx == len + 3'd2);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state    <= IDLE;
      idx      <= '0;
      cmd      <= '0;
      len      <= '0;
      data     <= '0;
      ACK      <= '0;
      GRANT_ID <= 3'(NUM_REQ - 1);
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      TX_DATA  <= '0;
      TX_START <= 1'b0;
    end else begin
      ACK      <= '0;
      DONE     <= 1'b0;
      TX_START <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            cmd      <= sel_cmd;
            len      <= sel_len;
            data     <= sel_data;
            ACK      <= ack_sel;
            GRANT_ID <= win;
            BUSY     <= 1'b1;
            idx      <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (!TX_BUSY) begin
            TX_DATA  <= byte_sel;
            TX_START <= 1'b1;
            state    <= GUARD;
          end
        end
        // The uart raises TX_BUSY one cycle after the strobe, so that cycle is not trusted.
        GUARD: state <= WAITTX;
        WAITTX: begin
          if (!TX_BUSY) begin
            if (last_byte) begin
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= idx + 3'd1;
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Bench for uart_tx_frame_arbiter: a uart responder, a frame-level reference model
// checked every cycle, directed scenarios and a randomized request phase.
module tb_uart_tx_frame_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [31:0]  req_cmd = '0;
  logic [11:0]  req_len = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   ack;
  logic [2:0]   grant_id;
  logic         busy, done, tx_start, tx_busy;
  logic [7:0]   tx_data;
  logic         stall = 1'b0;
  int           busy_cnt = 0;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;

  uart_tx_frame_arbiter #(.NUM_REQ(4), .MAX_LEN(4), .SYNC_BYTE(8'hFF)) dut (
    .CLOCK_50(clk), .RESET(rst), .REQ(req), .REQ_CMD(req_cmd), .REQ_LEN(req_len),
    .REQ_DATA(req_data), .ACK(ack), .GRANT_ID(grant_id), .BUSY(busy), .DONE(done),
    .TX_DATA(tx_data), .TX_START(tx_start), .TX_BUSY(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // uart responder: busy rises the cycle after a strobe and lasts a random byte time
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) busy_cnt <= 1 + int'($urandom % 5);
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || stall;

  // inputs as the DUT saw them at the last rising edge
  logic [3:0]   e_req;
  logic [31:0]  e_cmd;
  logic [11:0]  e_len;
  logic [127:0] e_data;
  logic         e_txbusy, e_rst;
  always @(posedge clk) begin
    e_req <= req; e_cmd <= req_cmd; e_len <= req_len; e_data <= req_data;
    e_txbusy <= tx_busy; e_rst <= rst;
  end

  // reference model: frame queue, grant history, guard/done timing
  logic [7:0] exp_q[$];
  logic [7:0] wire_log[$];
  int         order_q[$];
  bit         idle = 1'b1;
  int         last = 3;
  bit         armed = 1'b0;
  int         g = 0;
  int         last_start = -100;

  function automatic int rr(input logic [3:0] r, input int prev);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (prev + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    int w;
    int l;
    logic [3:0] exp_ack;
    logic exp_done;
    if (cyc != 0) begin
      if (e_rst) begin
        check_eq("rst_ack", 32'(ack), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_tx_start", 32'(tx_start), 0);
        check_eq("rst_tx_data", 32'(tx_data), 0);
        exp_q.delete();
        idle = 1'b1; last = 3; armed = 1'b0; g = 0; last_start = -100;
      end else begin
        exp_ack = '0;
        w = -1;
        if (idle && e_req != 4'b0) begin
          w = rr(e_req, last);
          exp_ack = 4'b0001 << w;
        end
        check_eq("ack", 32'(ack), 32'(exp_ack));
        if (w >= 0) begin
          last = w; idle = 1'b0; order_q.push_back(w);
          l = int'(e_len[3*w +: 3]);
          if (l > 4) l = 4;
          exp_q.push_back(8'hFF);
          exp_q.push_back(e_cmd[8*w +: 8]);
          exp_q.push_back(8'(l));
          for (int k = 0; k < l; k++) exp_q.push_back(e_data[32*w + 8*k +: 8]);
        end
        exp_done = 1'b0;
        if (armed) begin
          g++;
          if (g >= 2 && !e_txbusy) begin
            exp_done = 1'b1; armed = 1'b0; idle = 1'b1;
          end
        end
        check_eq("done", 32'(done), 32'(exp_done));
        if (tx_start) begin
          check_eq("start_while_busy", 32'(e_txbusy), 0);
          check_eq("start_spacing", 32'(cyc - last_start >= 3), 1);
          last_start = cyc;
          wire_log.push_back(tx_data);
          check_eq("byte_pending", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            check_eq("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
            if (exp_q.size() == 0) begin
              armed = 1'b1; g = 0;
            end
          end
        end
      end
      check_eq("busy", 32'(busy), 32'(!idle));
      check_eq("grant_id", 32'(grant_id), 32'(last));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input int i, output int at);
    int n = 0;
    do begin tick(); n++; end while (!ack[i] && n < 400);
    check_eq("ack_wait", 32'(ack[i]), 1);
    at = cyc;
  endtask

  task automatic wait_done(output int at);
    int n = 0;
    do begin tick(); n++; end while (!done && n < 600);
    check_eq("done_wait", 32'(done), 1);
    at = cyc;
  endtask

  task automatic wait_start();
    int n = 0;
    do begin tick(); n++; end while (!tx_start && n < 400);
    check_eq("start_wait", 32'(tx_start), 1);
  endtask

  task automatic serve(input string tag);
    int n = 0;
    do begin
      tick(); n++;
      for (int i = 0; i < 4; i++) if (ack[i]) req[i] = 1'b0;
    end while ((req != 4'b0 || busy) && n < 1000);
    check_eq(tag, 32'(req != 4'b0 || busy), 0);
  endtask

  task automatic set_req(input int i, input logic [7:0] c, input logic [2:0] l, input logic [31:0] d);
    req_cmd[8*i +: 8] = c;
    req_len[3*i +: 3] = l;
    req_data[32*i +: 32] = d;
    req[i] = 1'b1;
  endtask

  task automatic check_log(input string tag, input logic [7:0] e[$]);
    check_eq({tag, "_len"}, 32'(wire_log.size()), 32'(e.size()));
    for (int k = 0; k < e.size() && k < wire_log.size(); k++)
      check_eq(tag, 32'(wire_log[k]), 32'(e[k]));
  endtask

  task automatic check_order(input string tag, input int e[$]);
    check_eq({tag, "_len"}, 32'(order_q.size()), 32'(e.size()));
    for (int k = 0; k < e.size() && k < order_q.size(); k++)
      check_eq(tag, 32'(order_q[k]), 32'(e[k]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] e[$];
    int         o[$];
    int         at, done_at, a2, cnt;
    repeat (3) tick();
    check_eq("reset_grant", 32'(grant_id), 3);
    rst = 1'b0;

    // single request
    wire_log.delete();
    set_req(1, 8'h01, 3'd3, 32'h00_03_02_01);
    serve("single_serve");
    e = '{8'hFF, 8'h01, 8'h03, 8'h01, 8'h02, 8'h03};
    check_log("single_bytes", e);
    check_eq("single_grant", 32'(grant_id), 1);

    // round robin from reset: 1011 then 1111
    do_reset();
    order_q.delete();
    set_req(0, 8'h10, 3'd0, 32'h0); set_req(1, 8'h11, 3'd0, 32'h0); set_req(3, 8'h13, 3'd0, 32'h0);
    serve("rr1_serve");
    o = '{0, 1, 3};
    check_order("rr1_order", o);
    order_q.delete();
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h20 + i), 3'd1, 32'h0);
    serve("rr2_serve");
    o = '{0, 1, 2, 3};
    check_order("rr2_order", o);

    // length edges
    wire_log.delete();
    set_req(0, 8'hA5, 3'd0, 32'h0);
    serve("len0_serve");
    e = '{8'hFF, 8'hA5, 8'h00};
    check_log("len0_bytes", e);
    wire_log.delete();
    set_req(0, 8'h5A, 3'd7, 32'hDD_CC_BB_AA);
    serve("len7_serve");
    e = '{8'hFF, 8'h5A, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    check_log("len7_bytes", e);

    // uart stall after the CMD byte
    wire_log.delete();
    set_req(1, 8'h77, 3'd2, 32'h0000_BEEF);
    wait_ack(1, at); req[1] = 1'b0;
    wait_start(); wait_start();
    stall = 1'b1;
    cnt = 0;
    repeat (100) begin tick(); if (tx_start) cnt++; end
    check_eq("stall_no_start", 32'(cnt), 0);
    stall = 1'b0;
    tick();
    check_eq("stall_resume_wait", 32'(tx_start), 0);
    tick();
    check_eq("stall_resume_start", 32'(tx_start), 1);
    check_eq("stall_len_byte", 32'(tx_data), 8'h02);
    wait_done(at);
    e = '{8'hFF, 8'h77, 8'h02, 8'hEF, 8'hBE};
    check_log("stall_bytes", e);

    // reset during a payload byte
    set_req(3, 8'h33, 3'd4, 32'h44_33_22_11);
    wait_ack(3, at); req[3] = 1'b0;
    repeat (4) wait_start();
    rst = 1'b1;
    tick();
    check_eq("midrst_start", 32'(tx_start), 0);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_done", 32'(done), 0);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin tick(); if (done) cnt++; end
    check_eq("midrst_no_done", 32'(cnt), 0);
    wire_log.delete();
    set_req(2, 8'hC2, 3'd2, 32'h0000_9988);
    serve("after_rst_serve");
    e = '{8'hFF, 8'hC2, 8'h02, 8'h88, 8'h99};
    check_log("after_rst_bytes", e);

    // back-to-back re-request from requester 2
    wire_log.delete();
    set_req(2, 8'hB1, 3'd1, 32'h0000_0061);
    wait_ack(2, at);
    set_req(2, 8'hB2, 3'd2, 32'h0000_7372);
    wait_done(done_at);
    wait_ack(2, a2);
    req[2] = 1'b0;
    check_eq("b2b_ack_after_done", 32'(a2 - done_at), 1);
    wait_done(at);
    e = '{8'hFF, 8'hB1, 8'h01, 8'h61, 8'hFF, 8'hB2, 8'h02, 8'h72, 8'h73};
    check_log("b2b_bytes", e);

    // randomized traffic, withdrawals and uart stalls
    for (int n = 0; n < 3000; n++) begin
      tick();
      stall = ($urandom % 24 == 0);
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          if ($urandom % 4 == 0) set_req(i, 8'($urandom), 3'($urandom), $urandom);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom % 8 == 0) begin
          set_req(i, 8'($urandom), 3'($urandom), $urandom);
        end else if (req[i] && $urandom % 200 == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    stall = 1'b0;
    cnt = 0;
    while (busy && cnt < 600) begin tick(); cnt++; end
    check_eq("drain_idle", 32'(busy), 0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
